// File: rtl/popcount_seq_pkg.sv
// Shared definitions for the sequential nibble popcount block: FSM encoding,
// uio pin positions, the uio output-enable constant and per-mode scan limits.
package popcount_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int UIO_WR     = 0;
    localparam int UIO_SEL    = 1;
    localparam int UIO_START  = 2;
    localparam int UIO_MODE   = 3;
    localparam int UIO_BUSY   = 4;
    localparam int UIO_DONE   = 5;
    localparam int UIO_ZERO   = 6;
    localparam int UIO_PARITY = 7;

    localparam logic [7:0] UIO_OE_VALUE = 8'hF0;

    localparam logic [1:0] LAST_IDX_16 = 2'd3;
    localparam logic [1:0] LAST_IDX_8  = 2'd1;

    // Converts the one-hot count from ones_counter4 into a binary 0..4 value.
    function automatic logic [4:0] onehot_to_count(input logic [4:0] onehot);
        logic [4:0] count;
        count = 5'd0;
        for (int k = 0; k < 5; k++) begin
            if (onehot[k]) begin
                count = count | 5'(k);
            end
        end
        return count;
    endfunction

endpackage

// File: rtl/ones_counter4.sv
// Purely combinational 4-input ones counter with a one-hot result:
// bit k of count_onehot is set when exactly k inputs are high.
module ones_counter4 (
    input  logic [3:0] bits_in,
    output logic [4:0] count_onehot
);

    logic [2:0] sum;

    always_comb begin
        sum = {2'b00, bits_in[0]} + {2'b00, bits_in[1]}
            + {2'b00, bits_in[2]} + {2'b00, bits_in[3]};
        count_onehot = 5'b00000;
        case (sum)
            3'd0:    count_onehot = 5'b00001;
            3'd1:    count_onehot = 5'b00010;
            3'd2:    count_onehot = 5'b00100;
            3'd3:    count_onehot = 5'b01000;
            3'd4:    count_onehot = 5'b10000;
            default: count_onehot = 5'b00000;
        endcase
    end

endmodule

// File: rtl/tt_um_popcount_seq.sv
// Tiny Tapeout top: a 16-bit word is loaded bytewise, then scanned one nibble
// per enabled cycle to produce a 0..16 popcount with zero and parity flags.
module tt_um_popcount_seq (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    import popcount_seq_pkg::*;

    state_t      state_q, state_d;
    logic [15:0] word_q, word_d;
    logic [4:0]  acc_q, acc_d;
    logic [1:0]  idx_q, idx_d;
    logic        mode_q, mode_d;
    logic [4:0]  result_q, result_d;

    logic [3:0]  nibble;
    logic [4:0]  nibble_onehot;
    logic [4:0]  nibble_count;
    logic [1:0]  last_idx;
    logic        unused_uio_bits;

    assign unused_uio_bits = &{1'b0, uio_in[7:4]};

    always_comb begin
        nibble = word_q[3:0];
        case (idx_q)
            2'd0: nibble = word_q[3:0];
            2'd1: nibble = word_q[7:4];
            2'd2: nibble = word_q[11:8];
            2'd3: nibble = word_q[15:12];
            default: nibble = word_q[3:0];
        endcase
    end

    ones_counter4 u_ones_counter4 (
        .bits_in      (nibble),
        .count_onehot (nibble_onehot)
    );

    assign nibble_count = onehot_to_count(nibble_onehot);
    assign last_idx     = mode_q ? LAST_IDX_8 : LAST_IDX_16;

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        mode_d   = mode_q;
        result_d = result_q;
        if (ena) begin
            unique case (state_q)
                ST_IDLE: begin
                    // start wins over a simultaneous write
                    if (uio_in[UIO_START]) begin
                        state_d = ST_SCAN;
                        mode_d  = uio_in[UIO_MODE];
                        acc_d   = 5'd0;
                        idx_d   = 2'd0;
                    end else if (uio_in[UIO_WR]) begin
                        if (uio_in[UIO_SEL]) begin
                            word_d[15:8] = ui_in;
                        end else begin
                            word_d[7:0] = ui_in;
                        end
                    end
                end
                ST_SCAN: begin
                    if (idx_q == last_idx) begin
                        result_d = acc_q + nibble_count;
                        state_d  = ST_DONE;
                    end else begin
                        acc_d = acc_q + nibble_count;
                        idx_d = idx_q + 2'd1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            word_q   <= 16'd0;
            acc_q    <= 5'd0;
            idx_q    <= 2'd0;
            mode_q   <= 1'b0;
            result_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            mode_q   <= mode_d;
            result_q <= result_d;
        end
    end

    assign uo_out = {3'b000, result_q};

    always_comb begin
        uio_out             = 8'h00;
        uio_out[UIO_BUSY]   = (state_q == ST_SCAN);
        uio_out[UIO_DONE]   = (state_q == ST_DONE);
        uio_out[UIO_ZERO]   = (result_q == 5'd0);
        uio_out[UIO_PARITY] = result_q[0];
    end

    assign uio_oe = UIO_OE_VALUE;

endmodule

// File: tb/tb_tt_um_popcount_seq.sv
// Directed bench for tt_um_popcount_seq: expected popcounts are queued when a
// scan is started and compared when the done strobe appears.
module tb_tt_um_popcount_seq;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int failures;
    logic [15:0] model_word;
    logic [4:0]  sb_q[$];

    tt_um_popcount_seq dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] model_count(input logic mode);
        logic [15:0] w;
        w = mode ? {8'h00, model_word[7:0]} : model_word;
        return 5'($countones(w));
    endfunction

    task automatic write_byte(input logic sel, input logic [7:0] data);
        ui_in  = data;
        uio_in = {6'b000000, sel, 1'b1};
        tick();
        uio_in = 8'h00;
        if (ena) begin
            if (sel) model_word[15:8] = data;
            else     model_word[7:0]  = data;
        end
    endtask

    task automatic set_word(input logic [15:0] w);
        write_byte(1'b0, w[7:0]);
        write_byte(1'b1, w[15:8]);
    endtask

    // Starts a scan, optionally stalls with ena=0 or pokes wr/start mid-scan,
    // then checks busy length, the done pulse and the popped expected result.
    task automatic run_scan(input string tag, input logic mode, input int stall_len,
                            input logic poke);
        int busy_cycles;
        logic [4:0] exp_res;
        sb_q.push_back(model_count(mode));
        uio_in = {4'b0000, mode, 1'b1, 1'b0, 1'b0};
        tick();
        uio_in = 8'h00;
        busy_cycles = 0;
        while (uio_out[4] === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            if (busy_cycles == 1 && poke) begin
                ui_in  = 8'h00;
                uio_in = 8'h0D;
            end else begin
                uio_in = 8'h00;
            end
            if (busy_cycles == 2 && stall_len > 0) begin
                ena = 1'b0;
                repeat (stall_len) begin
                    tick();
                    busy_cycles++;
                end
                ena = 1'b1;
            end
            tick();
        end
        uio_in = 8'h00;
        check({tag, "_busy_len"}, 8'(busy_cycles), 8'((mode ? 2 : 4) + stall_len));
        check({tag, "_done"}, {7'd0, uio_out[5]}, 8'h01);
        if (sb_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 8'h01, 8'h00);
        end else begin
            exp_res = sb_q.pop_front();
            check({tag, "_result"}, uo_out, {3'b000, exp_res});
            check({tag, "_zero"}, {7'd0, uio_out[6]}, {7'd0, exp_res == 5'd0});
            check({tag, "_parity"}, {7'd0, uio_out[7]}, {7'd0, exp_res[0]});
            tick();
            check({tag, "_done_one_cycle"}, {6'd0, uio_out[5:4]}, 8'h00);
            check({tag, "_result_hold"}, uo_out, {3'b000, exp_res});
        end
    endtask

    initial begin
        logic saw_done;
        checks     = 0;
        failures   = 0;
        model_word = 16'h0000;
        rst_n      = 1'b0;
        ena        = 1'b1;
        ui_in      = 8'h00;
        uio_in     = 8'h00;
        repeat (2) tick();
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h40);
        check("uio_oe", uio_oe, 8'hF0);
        rst_n = 1'b1;
        tick();

        $display("[TB] all ones, 16-bit scan");
        set_word(16'hFFFF);
        run_scan("ffff_m0", 1'b0, 0, 1'b0);

        $display("[TB] zero word, disabled write ignored");
        set_word(16'h0000);
        ena = 1'b0;
        write_byte(1'b0, 8'hFF);
        ena = 1'b1;
        run_scan("zero_m0", 1'b0, 0, 1'b0);

        $display("[TB] A53C in both modes");
        set_word(16'hA53C);
        run_scan("a53c_m1", 1'b1, 0, 1'b0);
        run_scan("a53c_m0", 1'b0, 0, 1'b0);

        $display("[TB] wr/start ignored during scan");
        set_word(16'hFFFF);
        run_scan("poke", 1'b0, 0, 1'b1);
        run_scan("poke_again", 1'b0, 0, 1'b0);

        $display("[TB] stall with ena=0");
        set_word(16'h0F01);
        run_scan("stall", 1'b0, 3, 1'b0);

        $display("[TB] reset aborts scan");
        set_word(16'h1234);
        uio_in = 8'h04;
        tick();
        uio_in = 8'h00;
        tick();
        rst_n  = 1'b0;
        uio_in = 8'h05;
        tick();
        rst_n  = 1'b1;
        uio_in = 8'h00;
        model_word = 16'h0000;
        check("abort_busy_done", {6'd0, uio_out[5:4]}, 8'h00);
        check("abort_uo_out", uo_out, 8'h00);
        check("abort_zero_parity", {6'd0, uio_out[7:6]}, 8'h01);
        saw_done = 1'b0;
        repeat (8) begin
            tick();
            saw_done = saw_done | uio_out[5] | uio_out[4];
        end
        check("abort_no_done", {7'd0, saw_done}, 8'h00);
        run_scan("after_reset", 1'b0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_um_popcount_seq.md
TT_UM_POPCOUNT_SEQ -- requirements
Module: tt_um_popcount_seq

Interface
REQ-001 Parameters: none; all widths fixed by the Tiny Tapeout top-level pinout.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-004 ena  input  1  design enable; when 0, all state SHALL hold and no strobe is acted on.
REQ-005 ui_in  input  8  write data byte.
REQ-006 uo_out  output  8  [4:0] total popcount result (0..16); [7:5] tied 0.
REQ-007 uio_in  input  8  [0] wr strobe; [1] byte select (0 = low byte, 1 = high byte); [2] start; [3] mode (0 = 16-bit scan, 1 = 8-bit scan, low byte only); [7:4] ignored.
REQ-008 uio_out  output  8  [3:0] tied 0; [4] busy; [5] done; [6] zero flag (result == 0); [7] parity (result[0]).
REQ-009 uio_oe  output  8  constant 8'hF0.

Function
REQ-010 A 16-bit word register SHALL capture ui_in into the byte chosen by uio_in[1] on any edge with ena=1, wr=1, state IDLE and start=0.
REQ-011 FSM states: IDLE, SCAN, DONE.
REQ-012 IDLE -> SCAN on an edge with ena=1 and start=1; the same edge latches mode, clears accumulator and nibble index; wr on that edge is ignored.
REQ-013 In SCAN, each enabled edge SHALL add the one-count of word nibble [index] (0..4, from the 4-input ones counter) to a 5-bit accumulator and increment the index.
REQ-014 The last nibble index is 3 in 16-bit mode and 1 in 8-bit mode; the edge processing it SHALL load result <= accumulator + count and move to DONE.
REQ-015 DONE lasts exactly one enabled cycle and then returns to IDLE.
REQ-016 busy = 1 exactly while in SCAN; done = 1 exactly while in DONE.
REQ-017 Latency, start sampled at edge N (ena held 1): busy high cycles N+1..N+4 (16-bit) or N+1..N+2 (8-bit); done high for the one following cycle; result valid from the first done cycle onward.
REQ-018 Result, zero and parity SHALL hold their value until the next DONE entry; zero and parity derive from the result register only.
REQ-019 wr and start SHALL be ignored in SCAN and DONE; the word register does not change during a scan.
REQ-020 ena=0 in SCAN or DONE stalls the FSM; completion is delayed by exactly the number of disabled cycles and the result is unchanged.
REQ-021 Accumulator width is 5 bits; maximum 16 SHALL NOT overflow.

Reset
REQ-022 On an edge with rst_n=0: state IDLE, word 0, accumulator 0, index 0, mode 0, result 0; next cycle uo_out=8'h00, busy=0, done=0, zero=1, parity=0.
REQ-023 Reset SHALL take priority over ena, wr and start, and aborts a scan in progress with no done pulse.

Structure
REQ-024 Package popcount_seq_pkg holds the state encoding, uio bit positions, the OE constant 8'hF0 and the last-index constants for both modes.
REQ-025 One sub-module, ones_counter4: purely combinational, 4 inputs, 5-bit one-hot count output (bit k set when k inputs are 1); the controller encodes it to binary before accumulation.

Verification
REQ-026 Write low byte 8'hFF, high byte 8'hFF, start with mode 0 -> busy for 4 cycles, done for 1, uo_out=8'h10, zero=0, parity=0.
REQ-027 Word 16'h0000, start with mode 0 -> uo_out=8'h00, zero=1, parity=0.
REQ-028 Word 16'hA53C, start with mode 1 -> busy for 2 cycles, uo_out=4; then start with mode 0 -> uo_out=8, parity=0.
REQ-029 Word 16'hFFFF, start; during SCAN pulse wr of low byte 8'h00 and pulse start -> uo_out=16; a second start -> uo_out=16 again.
REQ-030 Reset asserted on the second SCAN cycle -> next cycle busy=0, done=0, uo_out=0, zero=1; done never pulses.
REQ-031 Word 16'h0F01, start, hold ena=0 for 3 cycles mid-SCAN -> done arrives 3 cycles late, uo_out=5, parity=1.
